// File: rtl/tp_adc_responder_if.sv
// Touch-panel ADC serial bus: controller-driven CS/DCLK/DIN, responder-driven
// DOUT/BUSY/PENIRQ.
interface tp_adc_responder_if;
  logic TP_CS;
  logic TP_DCLK;
  logic TP_DIN;
  logic TP_DOUT;
  logic TP_BUSY;
  logic TP_PENIRQ;

  modport master (
    output TP_CS, TP_DCLK, TP_DIN,
    input  TP_DOUT, TP_BUSY, TP_PENIRQ
  );

  modport slave (
    input  TP_CS, TP_DCLK, TP_DIN,
    output TP_DOUT, TP_BUSY, TP_PENIRQ
  );
endinterface

// File: rtl/tp_adc_responder.sv
// Behavioural ADS7843-style touch-panel ADC responder. Decodes the command
// byte clocked in on DCLK rises, emulates one DCLK period of BUSY, then
// shifts a 12- or 8-bit sample of x_pos/y_pos out on DCLK falls.
module tp_adc_responder #(
  parameter int unsigned CLKS_MIN = 4
) (
  input  logic                  clk,
  input  logic                  reset_btn,
  tp_adc_responder_if.slave     tp,
  input  logic                  pen_down,
  input  logic [11:0]           x_pos,
  input  logic [11:0]           y_pos,
  output logic                  cmd_valid,
  output logic [7:0]            cmd_byte
);

  // Edge detection runs 3 clk cycles behind the pins; shorter DCLK phases
  // can be merged or missed.
  if (CLKS_MIN < 3) begin : g_bad_clks_min
    $error("tp_adc_responder: CLKS_MIN must be at least 3");
  end

  typedef enum logic [1:0] {IDLE, CMD, CONV, DATA} state_t;

  state_t      state_q, state_d;
  logic        cs_s1, cs_s2, cs_d;
  logic        dclk_s1, dclk_s2, dclk_d;
  logic        din_s1, din_s2;
  logic        dclk_rise, dclk_fall, cs_rise, cs_fall;
  logic        pen_q;
  logic        pirq_en_q, pirq_en_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  cmd_byte_d;
  logic [11:0] res_q, res_d;
  logic [11:0] sel;
  logic [7:0]  byte_in;
  logic        mode_q, mode_d;
  logic        busy_q, busy_d;
  logic        dout_q, dout_d;
  logic        valid_d;

  // Synchronize the asynchronous bus inputs and keep a delayed copy for edges.
  // CS syncs reset low so a CS already low at reset release is not seen as a
  // fresh falling edge; the aborted transfer is therefore never resumed.
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      cs_s1   <= 1'b0;
      cs_s2   <= 1'b0;
      cs_d    <= 1'b0;
      dclk_s1 <= 1'b0;
      dclk_s2 <= 1'b0;
      dclk_d  <= 1'b0;
      din_s1  <= 1'b0;
      din_s2  <= 1'b0;
      pen_q   <= 1'b0;
    end else begin
      cs_s1   <= tp.TP_CS;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      dclk_s1 <= tp.TP_DCLK;
      dclk_s2 <= dclk_s1;
      dclk_d  <= dclk_s2;
      din_s1  <= tp.TP_DIN;
      din_s2  <= din_s1;
      pen_q   <= pen_down;
    end
  end

  assign dclk_rise = dclk_s2 & ~dclk_d;
  assign dclk_fall = ~dclk_s2 & dclk_d;
  assign cs_rise   = cs_s2 & ~cs_d;
  assign cs_fall   = ~cs_s2 & cs_d;

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      res_q     <= '0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      dout_q    <= 1'b0;
      pirq_en_q <= 1'b1;
      cmd_byte  <= '0;
      cmd_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      res_q     <= res_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      dout_q    <= dout_d;
      pirq_en_q <= pirq_en_d;
      cmd_byte  <= cmd_byte_d;
      cmd_valid <= valid_d;
    end
  end

  // Result selection from the channel bits of the byte being completed.
  always_comb begin
    byte_in = {sh_q[6:0], din_s2};
    case (byte_in[6:4])
      3'b101:  sel = x_pos;
      3'b001:  sel = y_pos;
      3'b011:  sel = pen_down ? '1 : '0;
      default: sel = '0;
    endcase
  end

  // Next-state and output logic; a CS rise aborts from any state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    res_d      = res_q;
    mode_d     = mode_q;
    busy_d     = busy_q;
    dout_d     = dout_q;
    pirq_en_d  = pirq_en_q;
    cmd_byte_d = cmd_byte;
    valid_d    = 1'b0;

    if (cs_rise) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      dout_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d = CMD;
            cnt_d   = '0;
          end
        end
        CMD: begin
          // Leading zeros before the start bit leave the count at 0.
          if (dclk_rise && (cnt_q != 4'd0 || din_s2)) begin
            sh_d = byte_in;
            if (cnt_q == 4'd7) begin
              cmd_byte_d = byte_in;
              valid_d    = 1'b1;
              res_d      = sel;
              mode_d     = byte_in[3];
              pirq_en_d  = (byte_in[1:0] == 2'b00);
              cnt_d      = '0;
              state_d    = CONV;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        CONV: begin
          if (dclk_fall) begin
            if (!busy_q) begin
              busy_d = 1'b1;
            end else begin
              busy_d  = 1'b0;
              dout_d  = res_q[11];
              res_d   = {res_q[10:0], 1'b0};
              cnt_d   = 4'd1;
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (dclk_fall) begin
            if (cnt_q == (mode_q ? 4'd8 : 4'd12)) begin
              dout_d  = 1'b0;
              cnt_d   = '0;
              state_d = CMD;
            end else begin
              dout_d = res_q[11];
              res_d  = {res_q[10:0], 1'b0};
              cnt_d  = cnt_q + 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign tp.TP_DOUT   = dout_q;
  assign tp.TP_BUSY   = busy_q;
  assign tp.TP_PENIRQ = ~(pen_q & pirq_en_q & cs_s2);

endmodule

// File: tb/tb_tp_adc_responder.sv
// Directed bench for tp_adc_responder: command decode, BUSY timing, serial
// data, CS abort, reset abort and pen interrupt gating.
module tb_tp_adc_responder;

  logic        clk;
  logic        reset_btn;
  logic        pen_down;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  int          total;
  int          bad;
  int          vcnt;

  tp_adc_responder_if ifc();

  tp_adc_responder #(.CLKS_MIN(4)) dut (
    .clk       (clk),
    .reset_btn (reset_btn),
    .tp        (ifc),
    .pen_down  (pen_down),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .cmd_valid (cmd_valid),
    .cmd_byte  (cmd_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every clk cycle that cmd_valid is high.
  always @(negedge clk) if (cmd_valid === 1'b1) vcnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One DCLK period, 6 clk per phase. Outputs are sampled just before the
  // rise, i.e. they show the action of the previous fall.
  task automatic bit_clk(input logic din, output logic dout_s, output logic busy_s);
    ifc.TP_DIN = din;
    repeat (6) @(negedge clk);
    dout_s = ifc.TP_DOUT;
    busy_s = ifc.TP_BUSY;
    ifc.TP_DCLK = 1'b1;
    repeat (6) @(negedge clk);
    ifc.TP_DCLK = 1'b0;
  endtask

  task automatic cs_low();
    ifc.TP_CS = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    ifc.TP_CS = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] cmd, input int lead0, input int nbits,
                      input logic [11:0] expw, input string tag);
    logic d, b, bsum;
    logic [11:0] got;
    int v0;
    v0 = vcnt;
    cs_low();
    for (int i = 0; i < lead0; i++) bit_clk(1'b0, d, b);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk({tag, " valid early"}, vcnt - v0, 0);
      bit_clk(cmd[7-i], d, b);
    end
    chk({tag, " valid"}, vcnt - v0, 1);
    chk({tag, " cmd_byte"}, cmd_byte, cmd);
    bit_clk(1'b0, d, b);
    chk({tag, " busy hi"}, b, 1'b1);
    got = '0;
    bsum = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bit_clk(1'b0, d, b);
      got = {got[10:0], d};
      bsum = bsum | b;
    end
    chk({tag, " busy lo"}, bsum, 1'b0);
    chk({tag, " data"}, got, expw);
    bit_clk(1'b0, d, b);
    chk({tag, " tail"}, d, 1'b0);
    cs_high();
    chk({tag, " valid end"}, vcnt - v0, 1);
  endtask

  initial begin
    logic d, b;
    int v0;
    total = 0;
    bad = 0;
    vcnt = 0;
    reset_btn = 1'b0;
    pen_down = 1'b0;
    x_pos = 12'hA5C;
    y_pos = 12'h3F7;
    ifc.TP_CS = 1'b0;
    ifc.TP_DCLK = 1'b0;
    ifc.TP_DIN = 1'b1;

    // Reset held with the bus active.
    for (int i = 0; i < 10; i++) bit_clk(1'b1, d, b);
    chk("rst dout", ifc.TP_DOUT, 1'b0);
    chk("rst busy", ifc.TP_BUSY, 1'b0);
    chk("rst penirq", ifc.TP_PENIRQ, 1'b1);
    chk("rst valid", vcnt, 0);
    chk("rst cmd_byte", cmd_byte, 8'h00);
    ifc.TP_CS = 1'b1;
    repeat (4) @(negedge clk);
    reset_btn = 1'b1;
    repeat (6) @(negedge clk);

    // X, 12-bit; Y, 8-bit; leading zeros; pen channel.
    xfer(8'hD0, 0, 12, 12'hA5C, "x12");
    xfer(8'h98, 0, 8, 12'h03F, "y8");
    xfer(8'hD0, 3, 12, 12'hA5C, "lead0");
    pen_down = 1'b1;
    xfer(8'hB0, 0, 12, 12'hFFF, "pench");
    pen_down = 1'b0;
    xfer(8'hE0, 0, 12, 12'h000, "ch110");

    // Partial command aborted by CS, then a full Y conversion.
    v0 = vcnt;
    cs_low();
    bit_clk(1'b1, d, b);
    bit_clk(1'b0, d, b);
    bit_clk(1'b0, d, b);
    bit_clk(1'b1, d, b);
    bit_clk(1'b0, d, b);
    cs_high();
    chk("partial valid", vcnt - v0, 0);
    xfer(8'h90, 0, 12, 12'h3F7, "y12");

    // Pen interrupt with PD = 00.
    pen_down = 1'b1;
    repeat (3) @(negedge clk);
    chk("pirq on", ifc.TP_PENIRQ, 1'b0);
    pen_down = 1'b0;
    repeat (3) @(negedge clk);
    chk("pirq off", ifc.TP_PENIRQ, 1'b1);
    pen_down = 1'b1;
    ifc.TP_CS = 1'b0;
    repeat (4) @(negedge clk);
    chk("pirq cs low", ifc.TP_PENIRQ, 1'b1);
    ifc.TP_CS = 1'b1;
    pen_down = 1'b0;
    repeat (6) @(negedge clk);

    // PD = 01 disables the pen interrupt.
    xfer(8'hD1, 0, 12, 12'hA5C, "xpd1");
    pen_down = 1'b1;
    repeat (4) @(negedge clk);
    chk("pirq pd1", ifc.TP_PENIRQ, 1'b1);
    pen_down = 1'b0;

    // Reset in the middle of data shifting.
    cs_low();
    for (int i = 0; i < 8; i++) bit_clk(x_pos[0] ? 1'b0 : (8'hD0 >> (7 - i)) & 1'b1, d, b);
    for (int i = 0; i < 4; i++) bit_clk(1'b0, d, b);
    reset_btn = 1'b0;
    @(negedge clk);
    chk("mid rst dout", ifc.TP_DOUT, 1'b0);
    chk("mid rst busy", ifc.TP_BUSY, 1'b0);
    chk("mid rst cmd_byte", cmd_byte, 8'h00);
    repeat (2) @(negedge clk);
    reset_btn = 1'b1;
    v0 = vcnt;
    for (int i = 0; i < 8; i++) bit_clk(1'b1, d, b);
    for (int i = 0; i < 3; i++) bit_clk(1'b0, d, b);
    chk("post rst valid", vcnt - v0, 0);
    chk("post rst busy", b, 1'b0);
    cs_high();
    pen_down = 1'b1;
    repeat (4) @(negedge clk);
    chk("post rst pirq", ifc.TP_PENIRQ, 1'b0);
    pen_down = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tp_adc_responder.md
# tp_adc_responder

Synthesizable behavioural responder for the 4-wire resistive touch-panel ADC (ADS7843-style) serial interface. It sits on the far end of the TP_CS/TP_DCLK/TP_DIN/TP_DOUT/TP_BUSY/TP_PENIRQ bus driven by the touch-panel controller. It decodes the 8-bit control byte, emulates the BUSY cycle, and shifts back a 12- or 8-bit sample of a host-supplied X/Y position. It is used in simulation and on an FPGA loopback to exercise the controller without the physical panel.

## Interface
- CLKS_MIN, 4: minimum `clk` cycles per DCLK high or low phase that the block is guaranteed to track.
- clk  in  1  system clock; all logic on the rising edge.
- reset_btn  in  1  asynchronous, active-low reset.
- TP_CS  in  1  chip select, active low; asynchronous to `clk`.
- TP_DCLK  in  1  serial clock from the controller; asynchronous to `clk`.
- TP_DIN  in  1  serial command data, MSB first.
- pen_down  in  1  stimulus; 1 = panel touched.
- x_pos  in  12  X sample value returned for channel 3'b101.
- y_pos  in  12  Y sample value returned for channel 3'b001.
- TP_DOUT  out  1  serial conversion data, MSB first.
- TP_BUSY  out  1  high for one DCLK period after the command byte.
- TP_PENIRQ  out  1  pen interrupt, active low.
- cmd_valid  out  1  one-`clk` pulse when a full command byte is captured.
- cmd_byte  out  8  last captured command byte.

## Operation
- TP_CS, TP_DCLK and TP_DIN each pass through 2-flop synchronizers. DCLK rise and fall are detected from the synchronized value and its 1-cycle delay.
- Command byte bits are {S, A2, A1, A0, MODE, SER/DFR, PD1, PD0}.
- States: IDLE, CMD, CONV, DATA.
- IDLE: entered while CS is high. On the synchronized CS falling edge -> CMD with bit count 0.
- CMD: DIN is sampled on each DCLK rise.
  - Leading zeros are ignored: the count does not advance until a 1 (start bit) is sampled.
  - The start bit plus 7 more bits fill the shift register.
  - On the 8th bit: cmd_byte <= byte, cmd_valid pulses for 1 cycle, and the result is snapshotted.
  - Result selection by A2..A0: 101 -> x_pos; 001 -> y_pos; 011 -> 12'hFFF if pen_down, else 12'h000; all other codes -> 12'h000.
  - After the 8th bit -> CONV.
- CONV:
  - First DCLK fall: TP_BUSY <= 1.
  - Second DCLK fall: TP_BUSY <= 0, TP_DOUT <= result MSB, -> DATA.
- DATA: each DCLK fall shifts the next bit onto TP_DOUT.
  - MODE = 0 sends 12 bits, result[11:0].
  - MODE = 1 sends 8 bits, result[11:4].
  - The fall after the last bit drives TP_DOUT <= 0 and -> CMD (bit count 0).
  - DIN is ignored in DATA; there are no overlapped conversions.
- TP_PENIRQ:
  - A register pirq_en is set to 1 on reset and loaded with (PD1..PD0 == 2'b00) at each captured command.
  - TP_PENIRQ = ~(pen_down & pirq_en & CS_synced_high). It is forced to 1 while CS is low.
- CS rising (synchronized) in any state: -> IDLE immediately. TP_BUSY <= 0, TP_DOUT <= 0, bit count cleared, and a partial command is discarded (no cmd_valid).

## Timing
- Reset values: TP_DOUT 0, TP_BUSY 0, TP_PENIRQ 1, cmd_valid 0, cmd_byte 8'h00, state IDLE, pirq_en 1.
- Reset asserted mid-transfer aborts at once to the reset values. After release the block waits in IDLE until it sees a CS falling edge; it does not resume the aborted transfer.
- Latency from a raw DCLK edge to its action (sample, or TP_DOUT/TP_BUSY update) is exactly 3 `clk` cycles: 2 synchronizer cycles plus 1 register.
- cmd_valid asserts on the same cycle as the 8th-rise action.
- Correct operation requires each DCLK phase to last at least CLKS_MIN `clk` cycles. DIN must be stable for 3 `clk` cycles around each DCLK rise.
- TP_PENIRQ reacts to pen_down with 1 cycle of latency. CS affects it after the 2-cycle synchronizer.
- Per conversion: 8 rises for the command, BUSY high for exactly one DCLK period, then 12 (or 8) data falls. The controller may issue the next start bit on any rise after the post-data fall.

## Test plan
- Reset held low with DCLK toggling -> TP_DOUT = 0, TP_BUSY = 0, TP_PENIRQ = 1, and cmd_valid never pulses.
- CS low, command 8'hD0 (X, 12-bit, PD = 00), x_pos = 12'hA5C:
  - cmd_byte = 8'hD0 and one cmd_valid pulse.
  - TP_BUSY is high for one DCLK period.
  - TP_DOUT on falls 2..13 after the command is 1010_0101_1100, then 0.
- Command 8'h98 (Y, 8-bit), y_pos = 12'h3F7 -> 8 data bits 0011_1111, then TP_DOUT = 0.
- Three leading zero bits before 8'hD0 -> same response as the 8'hD0 case above; cmd_valid fires only after 8 bits following the start bit.
- CS raised after 5 command bits, then a new full 8'h90 -> no cmd_valid for the partial byte; the second transfer returns y_pos correctly.
- CS high, pen_down = 1, last PD = 00 -> TP_PENIRQ = 0. After command 8'hD1 (PD0 = 1) and CS high, pen_down = 1 -> TP_PENIRQ stays 1.
